// File: rtl/z80_busrq_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : z80_busrq_arbiter
//  Description : Shares the Z80 system bus between NUM_REQ external bus
//                masters through the CPU nBUSRQ/nBUSACK handshake.
//                Round-robin winner selection, one owner at a time, optional
//                hold-time preemption and a guaranteed CPU window between
//                consecutive grants.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    NUM_REQ   number of requesting masters (2..8)
//    HOLD_MAX  grant cycles before preemption when another master waits;
//              0 disables preemption
//    CPU_SLOT  minimum extra cycles the CPU keeps the bus between grants
//  Ports
//    CLK       in   system clock, all state changes on the rising edge
//    RESET     in   asynchronous active-high reset
//    req       in   level request per master, held until the transfer is done
//    gnt       out  one-hot grant; a master drives the bus only while set
//    owner     out  index of the granted master, meaningful only when |gnt
//    busy      out  high whenever the arbiter is not idle
//    nBUSRQ    out  bus request to the CPU, active low
//    nBUSACK   in   bus acknowledge from the CPU, active low
// ============================================================================
module z80_busrq_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int HOLD_MAX = 64,
    parameter int CPU_SLOT = 8
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic                       busy,
    output logic                       nBUSRQ,
    input  logic                       nBUSACK
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    // One spare count of headroom so the saturation value itself is representable.
    localparam int HOLD_W = $clog2(HOLD_MAX + 2);

    localparam logic [HOLD_W-1:0] c_holdMax  = HOLD_W'(HOLD_MAX);
    localparam logic [HOLD_W-1:0] c_holdLast = HOLD_W'(HOLD_MAX - 1);
    localparam logic [7:0]        c_cpuSlot  = 8'(CPU_SLOT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_GRANT   = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t               r_state,   w_state;
    logic [NUM_REQ-1:0]   r_gnt,     w_gnt;
    logic [IDX_W-1:0]     r_owner,   w_owner;
    logic                 r_nBusRq,  w_nBusRq;
    logic [IDX_W-1:0]     r_rrPtr,   w_rrPtr;
    logic [HOLD_W-1:0]    r_holdCnt, w_holdCnt;
    logic [7:0]           r_slotCnt, w_slotCnt;

    logic [IDX_W-1:0]     w_winner;
    logic                 w_anyReq;
    logic                 w_ownerReq;
    logic                 w_otherReq;
    logic                 w_preempt;
    logic [NUM_REQ-1:0]   w_ownerMask;

    // Index arithmetic modulo NUM_REQ; NUM_REQ need not be a power of two.
    function automatic logic [IDX_W-1:0] wrapInc(input logic [IDX_W-1:0] base, input int step);
        int s;
        s = int'(base) + step;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return IDX_W'(s);
    endfunction

    // Round-robin search: scanning offsets from the far end down to zero lets
    // the nearest requester at or after rrPtr overwrite any farther one.
    always_comb begin
        w_winner = r_rrPtr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[wrapInc(r_rrPtr, k)]) begin
                w_winner = wrapInc(r_rrPtr, k);
            end
        end
    end

    assign w_anyReq    = |req;
    assign w_ownerMask = NUM_REQ'(1) << r_owner;
    assign w_ownerReq  = req[r_owner];
    assign w_otherReq  = |(req & ~w_ownerMask);
    // Preempt on the last permitted cycle so the grant lasts exactly HOLD_MAX cycles.
    assign w_preempt   = (HOLD_MAX != 0) && (r_holdCnt == c_holdLast) && w_otherReq;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state   <= ST_IDLE;
            r_gnt     <= '0;
            r_owner   <= '0;
            r_nBusRq  <= 1'b1;
            r_rrPtr   <= '0;
            r_holdCnt <= '0;
            r_slotCnt <= '0;
        end else begin
            r_state   <= w_state;
            r_gnt     <= w_gnt;
            r_owner   <= w_owner;
            r_nBusRq  <= w_nBusRq;
            r_rrPtr   <= w_rrPtr;
            r_holdCnt <= w_holdCnt;
            r_slotCnt <= w_slotCnt;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_gnt     = r_gnt;
        w_owner   = r_owner;
        w_nBusRq  = r_nBusRq;
        w_rrPtr   = r_rrPtr;
        w_holdCnt = r_holdCnt;
        w_slotCnt = r_slotCnt;

        case (r_state)
            ST_IDLE: begin
                // The CPU window must run out before a new arbitration; an
                // early nBUSACK from the CPU is of no interest here.
                if (r_slotCnt != 8'd0) begin
                    w_slotCnt = r_slotCnt - 8'd1;
                end else if (w_anyReq) begin
                    w_owner  = w_winner;
                    w_nBusRq = 1'b0;
                    w_state  = ST_REQ;
                end
            end

            ST_REQ: begin
                // A withdrawn request wins over an acknowledge arriving in the
                // same cycle: the master no longer wants the bus.
                if (!w_ownerReq) begin
                    w_nBusRq = 1'b1;
                    w_rrPtr  = wrapInc(r_owner, 1);
                    w_state  = ST_RELEASE;
                end else if (!nBUSACK) begin
                    w_gnt     = w_ownerMask;
                    w_holdCnt = '0;
                    w_state   = ST_GRANT;
                end
            end

            ST_GRANT: begin
                if (r_holdCnt != c_holdMax) begin
                    w_holdCnt = r_holdCnt + HOLD_W'(1);
                end
                if (!w_ownerReq || w_preempt) begin
                    w_gnt    = '0;
                    w_nBusRq = 1'b1;
                    w_rrPtr  = wrapInc(r_owner, 1);
                    w_state  = ST_RELEASE;
                end
            end

            ST_RELEASE: begin
                // Wait for the CPU to take the bus back; the CPU window starts here.
                if (nBUSACK) begin
                    w_slotCnt = c_cpuSlot;
                    w_state   = ST_IDLE;
                end
            end

            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    assign gnt    = r_gnt;
    assign owner  = r_owner;
    assign nBUSRQ = r_nBusRq;
    assign busy   = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_z80_busrq_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_z80_busrq_arbiter
//  Description : Self-checking bench for z80_busrq_arbiter. A main instance
//                (HOLD_MAX=64) and a second instance with preemption disabled
//                (HOLD_MAX=0) share clock and reset. The CPU is either driven
//                by hand or modelled as acknowledging two cycles after nBUSRQ.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_z80_busrq_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int HOLD_MAX = 64;
    localparam int CPU_SLOT = 8;

    typedef struct {
        logic [1:0] owner;
        int         len;    // expected grant length in cycles, 0 = not checked
    } exp_t;

    logic       CLK   = 1'b0;
    logic       RESET = 1'b1;

    // main instance
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic       nBUSRQ;
    logic       nBUSACK;
    logic       cpuAuto = 1'b0;
    logic       manAck  = 1'b1;
    logic [1:0] ackPipe;

    // no-preemption instance
    logic [3:0] req0 = 4'b0000;
    logic [3:0] gnt0;
    logic [1:0] owner0;
    logic       busy0;
    logic       nBUSRQ0;
    logic       nBUSACK0;
    logic [1:0] ackPipe0;

    int   checks = 0;
    int   errors = 0;
    exp_t sbQ[$];

    always #5 CLK = ~CLK;

    // CPU model: nBUSACK follows nBUSRQ two clock edges later.
    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ackPipe  <= 2'b11;
            ackPipe0 <= 2'b11;
        end else begin
            ackPipe  <= {ackPipe[0], nBUSRQ};
            ackPipe0 <= {ackPipe0[0], nBUSRQ0};
        end
    end

    assign nBUSACK  = cpuAuto ? ackPipe[1] : manAck;
    assign nBUSACK0 = ackPipe0[1];

    z80_busrq_arbiter #(
        .NUM_REQ (NUM_REQ),
        .HOLD_MAX(HOLD_MAX),
        .CPU_SLOT(CPU_SLOT)
    ) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .req    (req),
        .gnt    (gnt),
        .owner  (owner),
        .busy   (busy),
        .nBUSRQ (nBUSRQ),
        .nBUSACK(nBUSACK)
    );

    z80_busrq_arbiter #(
        .NUM_REQ (NUM_REQ),
        .HOLD_MAX(0),
        .CPU_SLOT(CPU_SLOT)
    ) dut0 (
        .CLK    (CLK),
        .RESET  (RESET),
        .req    (req0),
        .gnt    (gnt0),
        .owner  (owner0),
        .busy   (busy0),
        .nBUSRQ (nBUSRQ0),
        .nBUSACK(nBUSACK0)
    );

    // Wait for a grant on the main instance and compare it with the scoreboard head.
    task automatic waitGrant(input int budget);
        int   cyc = 0;
        exp_t e;
        while (gnt == 4'b0000 && cyc < budget) begin
            @(negedge CLK);
            cyc++;
        end
        checks++;
        if (gnt == 4'b0000) begin
            errors++;
            $display("FAIL grant_timeout: gnt=%b after %0d cycles, required a grant", gnt, cyc);
            if (sbQ.size() > 0) void'(sbQ.pop_front());
        end else if (sbQ.size() == 0) begin
            errors++;
            $display("FAIL grant_unexpected: gnt=%b owner=%0d, required no grant", gnt, owner);
        end else begin
            e = sbQ.pop_front();
            if (owner !== e.owner || gnt !== (4'b0001 << e.owner)) begin
                errors++;
                $display("FAIL grant_owner: gnt=%b owner=%0d, required owner=%0d", gnt, owner, e.owner);
            end
        end
    endtask

    task automatic waitIdle(input int budget);
        int cyc = 0;
        while (busy !== 1'b0 && cyc < budget) begin
            @(negedge CLK);
            cyc++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", busy, cyc);
        end
    endtask

    // Scoreboard monitor: every grant start is checked against the queue head,
    // every grant end against its expected length, and every gap for the CPU window.
    task automatic watchGrants(input int nGrants, input int budget);
        int         seen  = 0;
        int         cyc   = 0;
        int         hiLen = 0;
        int         gap   = 0;
        bit         first = 1'b1;
        logic [3:0] prevGnt;
        exp_t       cur;
        cur.owner = 2'd0;
        cur.len   = 0;
        prevGnt   = gnt;
        while (seen < nGrants && cyc < budget) begin
            @(negedge CLK);
            cyc++;
            if (gnt != 4'b0000 && prevGnt == 4'b0000) begin
                checks++;
                if (sbQ.size() == 0) begin
                    errors++;
                    $display("FAIL rot_unexpected: gnt=%b owner=%0d, required no grant", gnt, owner);
                end else begin
                    cur = sbQ.pop_front();
                    if (owner !== cur.owner || gnt !== (4'b0001 << cur.owner)) begin
                        errors++;
                        $display("FAIL rot_owner: gnt=%b owner=%0d, required owner=%0d", gnt, owner, cur.owner);
                    end
                end
                if (!first) begin
                    checks++;
                    if (gap < CPU_SLOT + 1) begin
                        errors++;
                        $display("FAIL rot_cpu_window: %0d cycles, required >= %0d", gap, CPU_SLOT + 1);
                    end
                end
                hiLen = 1;
            end else if (gnt != 4'b0000) begin
                hiLen++;
            end else if (prevGnt != 4'b0000) begin
                seen++;
                if (cur.len != 0) begin
                    checks++;
                    if (hiLen != cur.len) begin
                        errors++;
                        $display("FAIL rot_length: grant %0d lasted %0d cycles, required %0d", seen, hiLen, cur.len);
                    end
                end
                first = 1'b0;
                gap   = 0;
            end
            if (gnt == 4'b0000 && nBUSRQ === 1'b1 && nBUSACK === 1'b1) gap++;
            prevGnt = gnt;
        end
        checks++;
        if (seen < nGrants) begin
            errors++;
            $display("FAIL rot_timeout: %0d grants completed, required %0d", seen, nGrants);
        end
    endtask

    // Auto-CPU grant of a single master, used to steer the round-robin pointer.
    task automatic doGrant(input logic [3:0] r, input logic [1:0] expOwner);
        cpuAuto = 1'b1;
        sbQ.push_back(exp_t'{owner: expOwner, len: 0});
        req = r;
        waitGrant(50);
        repeat (3) @(negedge CLK);
        req = 4'b0000;
        waitIdle(50);
        repeat (CPU_SLOT + 2) @(negedge CLK);
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        checks += 4;
        if (gnt !== 4'b0000)  begin errors++; $display("FAIL reset_gnt: %b, required 0000", gnt); end
        if (nBUSRQ !== 1'b1)  begin errors++; $display("FAIL reset_nbusrq: %b, required 1", nBUSRQ); end
        if (owner !== 2'd0)   begin errors++; $display("FAIL reset_owner: %0d, required 0", owner); end
        if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: %b, required 0", busy); end
        RESET = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_single();
        exp_t e;
        cpuAuto = 1'b0;
        manAck  = 1'b1;
        req     = 4'b0010;
        @(negedge CLK);
        checks += 3;
        if (nBUSRQ !== 1'b0) begin errors++; $display("FAIL single_nbusrq_low: %b, required 0", nBUSRQ); end
        if (owner !== 2'd1)  begin errors++; $display("FAIL single_owner_latch: %0d, required 1", owner); end
        if (busy !== 1'b1)   begin errors++; $display("FAIL single_busy: %b, required 1", busy); end
        repeat (2) @(negedge CLK);
        checks++;
        if (gnt !== 4'b0000) begin errors++; $display("FAIL single_no_early_gnt: %b, required 0000", gnt); end
        sbQ.push_back(exp_t'{owner: 2'd1, len: 0});
        manAck = 1'b0;
        @(negedge CLK);
        e = sbQ.pop_front();
        checks++;
        if (gnt !== (4'b0001 << e.owner) || owner !== e.owner) begin
            errors++;
            $display("FAIL single_gnt: gnt=%b owner=%0d, required gnt=0010 owner=%0d", gnt, owner, e.owner);
        end
        repeat (3) @(negedge CLK);
        req = 4'b0000;
        @(negedge CLK);
        checks += 2;
        if (gnt !== 4'b0000) begin errors++; $display("FAIL single_drop_gnt: %b, required 0000", gnt); end
        if (nBUSRQ !== 1'b1) begin errors++; $display("FAIL single_drop_nbusrq: %b, required 1", nBUSRQ); end
        repeat (3) @(negedge CLK);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL single_release_wait: busy=%b, required 1", busy); end
        manAck = 1'b1;
        @(negedge CLK);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: busy=%b, required 0", busy); end
        repeat (CPU_SLOT + 2) @(negedge CLK);
    endtask

    task automatic test_rotate();
        RESET = 1'b1;
        @(negedge CLK);
        RESET   = 1'b0;
        cpuAuto = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sbQ.push_back(exp_t'{owner: 2'(i % 4), len: HOLD_MAX});
        end
        req = 4'b1111;
        watchGrants(5, 1000);
        req = 4'b0000;
        sbQ.delete();
        waitIdle(50);
        repeat (CPU_SLOT + 2) @(negedge CLK);
    endtask

    task automatic test_wrap();
        doGrant(4'b0010, 2'd1);     // leaves the pointer at 2
        cpuAuto = 1'b0;
        manAck  = 1'b1;
        req     = 4'b0011;
        @(negedge CLK);
        checks++;
        if (owner !== 2'd0 || nBUSRQ !== 1'b0) begin
            errors++;
            $display("FAIL wrap_winner: owner=%0d nBUSRQ=%b, required owner=0 nBUSRQ=0", owner, nBUSRQ);
        end
        req = 4'b0111;
        repeat (2) @(negedge CLK);
        checks++;
        if (owner !== 2'd0) begin errors++; $display("FAIL wrap_owner_stable: %0d, required 0", owner); end
        sbQ.push_back(exp_t'{owner: 2'd0, len: 0});
        manAck = 1'b0;
        waitGrant(5);
        req = 4'b0000;
        @(negedge CLK);
        manAck = 1'b1;
        waitIdle(10);
        repeat (CPU_SLOT + 2) @(negedge CLK);
    endtask

    task automatic test_abort();
        bit sawGnt = 1'b0;
        cpuAuto = 1'b0;
        manAck  = 1'b1;
        req     = 4'b1000;
        @(negedge CLK);
        checks++;
        if (owner !== 2'd3 || nBUSRQ !== 1'b0) begin
            errors++;
            $display("FAIL abort_winner: owner=%0d nBUSRQ=%b, required owner=3 nBUSRQ=0", owner, nBUSRQ);
        end
        req = 4'b0000;
        @(negedge CLK);
        checks += 2;
        if (nBUSRQ !== 1'b1) begin errors++; $display("FAIL abort_nbusrq: %b, required 1", nBUSRQ); end
        if (gnt !== 4'b0000) begin errors++; $display("FAIL abort_gnt: %b, required 0000", gnt); end
        for (int i = 0; i < CPU_SLOT + 3; i++) begin
            @(negedge CLK);
            if (gnt != 4'b0000) sawGnt = 1'b1;
        end
        checks += 2;
        if (sawGnt) begin errors++; $display("FAIL abort_gnt_never: grant seen, required none"); end
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle: busy=%b, required 0", busy); end
        req = 4'b1001;
        @(negedge CLK);
        checks++;
        if (owner !== 2'd0) begin errors++; $display("FAIL abort_next_search: owner=%0d, required 0", owner); end
        req = 4'b0000;
        waitIdle(10);
        repeat (CPU_SLOT + 2) @(negedge CLK);
    endtask

    task automatic test_nopreempt();
        int         rises   = 0;
        int         falls   = 0;
        int         granted = 0;
        logic [3:0] prev    = 4'b0000;
        exp_t       e;
        sbQ.push_back(exp_t'{owner: 2'd0, len: 0});
        req0 = 4'b0011;
        for (int i = 0; i < 1000; i++) begin
            @(negedge CLK);
            if (gnt0 != 4'b0000 && prev == 4'b0000) begin
                rises++;
                checks++;
                e = sbQ.pop_front();
                if (gnt0 !== (4'b0001 << e.owner) || owner0 !== e.owner) begin
                    errors++;
                    $display("FAIL nopre_owner: gnt=%b owner=%0d, required owner=%0d", gnt0, owner0, e.owner);
                end
            end
            if (gnt0 == 4'b0000 && prev != 4'b0000) falls++;
            if (gnt0 == 4'b0001) granted++;
            prev = gnt0;
        end
        checks += 3;
        if (rises != 1)    begin errors++; $display("FAIL nopre_grant_count: %0d grants, required 1", rises); end
        if (falls != 0)    begin errors++; $display("FAIL nopre_preempted: %0d drops, required 0", falls); end
        if (granted < 990) begin errors++; $display("FAIL nopre_hold: %0d cycles granted, required >= 990", granted); end
        sbQ.delete();
        req0 = 4'b0000;
        repeat (CPU_SLOT + 6) @(negedge CLK);
    endtask

    task automatic test_async_reset();
        sbQ.push_back(exp_t'{owner: 2'd2, len: 0});
        cpuAuto = 1'b1;
        req     = 4'b0100;
        waitGrant(50);
        @(posedge CLK);
        #3;
        RESET = 1'b1;
        #1;
        checks += 3;
        if (gnt !== 4'b0000) begin errors++; $display("FAIL areset_gnt: %b, required 0000", gnt); end
        if (nBUSRQ !== 1'b1) begin errors++; $display("FAIL areset_nbusrq: %b, required 1", nBUSRQ); end
        if (busy !== 1'b0)   begin errors++; $display("FAIL areset_busy: %b, required 0", busy); end
        req = 4'b0000;
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotate();
        test_wrap();
        test_abort();
        test_nopreempt();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
